// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    // Instruction word loaded into ID/EX when a bubble is inserted (addi x0,x0,0)
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MC_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // Count enabled cycles, sticking at all-ones; clear wins over enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: load-use stalls, EX redirects and
// multi-cycle op sequencing with a watchdog. Optional hazard statistics
// counters are enabled by defining HAZARD_STATS_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_mc_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_redirect_i,
    input  logic              mc_done_i,
    output logic              pc_write_o,
    output logic              ID_redo_o,
    output logic              branch_flush_o,
    output logic              idex_bubble_o,
    output logic              mc_issue_o,
    output logic              mc_timeout_o,
    output logic [1:0]        state_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int unsigned LU_CNT_W = 2;
    localparam int unsigned MC_CNT_W = 8;
    localparam logic [LU_CNT_W-1:0] LU_LOAD = LU_CNT_W'(LU_STALL_CYC - 1);
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

    state_e              state_q;
    state_e              state_d;
    logic [LU_CNT_W-1:0] lu_cnt_q;
    logic [LU_CNT_W-1:0] lu_cnt_d;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic                mc_clr;
    logic                mc_en;
    logic                tmo_q;
    logic                tmo_set;
    logic                lu_hit;

    // Load in EX writes a register the instruction in ID is about to read
    assign lu_hit = ex_memread_i && (ex_rd_i != '0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Mealy decode of control outputs and next state
    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        pc_write_o     = 1'b1;
        ID_redo_o      = 1'b0;
        branch_flush_o = 1'b0;
        idex_bubble_o  = 1'b0;
        mc_issue_o     = 1'b0;
        tmo_set        = 1'b0;
        mc_clr         = 1'b0;
        mc_en          = 1'b0;

        case (state_q)
            ST_LU_STALL: begin
                if (ex_redirect_i) begin
                    branch_flush_o = 1'b1;
                    idex_bubble_o  = 1'b1;
                    lu_cnt_d       = '0;
                    state_d        = ST_RUN;
                end else begin
                    ID_redo_o     = 1'b1;
                    pc_write_o    = 1'b0;
                    idex_bubble_o = 1'b1;
                    lu_cnt_d      = lu_cnt_q - LU_CNT_W'(1);
                    if (lu_cnt_q <= LU_CNT_W'(1)) begin
                        lu_cnt_d = '0;
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_MC_BUSY: begin
                // Redirects cannot occur here: EX only holds bubbles
                if (mc_done_i) begin
                    state_d = ST_RUN;
                end else if (mc_cnt == MC_LAST) begin
                    tmo_set = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    ID_redo_o     = 1'b1;
                    pc_write_o    = 1'b0;
                    idex_bubble_o = 1'b1;
                    mc_en         = 1'b1;
                end
            end

            default: begin
                // RUN, and the unused encoding which behaves as RUN
                state_d = ST_RUN;
                if (ex_redirect_i) begin
                    branch_flush_o = 1'b1;
                    idex_bubble_o  = 1'b1;
                end else if (lu_hit) begin
                    ID_redo_o     = 1'b1;
                    pc_write_o    = 1'b0;
                    idex_bubble_o = 1'b1;
                    if (LU_STALL_CYC > 1) begin
                        lu_cnt_d = LU_LOAD;
                        state_d  = ST_LU_STALL;
                    end
                end else if (id_mc_i) begin
                    mc_issue_o = 1'b1;
                    mc_clr     = 1'b1;
                    state_d    = ST_MC_BUSY;
                end
            end
        endcase

        // While reset is held the pipeline simply advances with nothing in flight
        if (rst_i) begin
            pc_write_o     = 1'b1;
            ID_redo_o      = 1'b0;
            branch_flush_o = 1'b0;
            idex_bubble_o  = 1'b0;
            mc_issue_o     = 1'b0;
        end
    end

    // State, load-use countdown and sticky watchdog flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            lu_cnt_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            tmo_q    <= tmo_q | tmo_set;
        end
    end

    assign state_o      = state_q;
    assign mc_timeout_o = tmo_q;

    // Cycles spent waiting on the multi-cycle unit
    sat_counter #(.WIDTH(MC_CNT_W)) u_mc_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (mc_clr),
        .en    (mc_en),
        .q     (mc_cnt)
    );

`ifdef HAZARD_STATS_EN
    // Saturating counts of ID hold cycles and IF/ID flush cycles
    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (1'b0),
        .en    (ID_redo_o),
        .q     (stall_cnt_o)
    );

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (1'b0),
        .en    (branch_flush_o),
        .q     (flush_cnt_o)
    );
`else
    // No statistics counters in this build
`endif

`ifndef SYNTHESIS
    // A redirect while the multi-cycle unit is busy means EX was not bubbled
    a_no_redirect_in_mc : assert property (
        @(posedge clk_i) disable iff (rst_i)
        !((state_q == ST_MC_BUSY) && ex_redirect_i)
    );
`endif

endmodule
